// File: rtl/prog_tick_divider_pkg.sv
// tick_div_pkg: shared constants and helpers for the programmable tick divider.
//   DEF_CLK_HZ / DEF_CNT_W / DEF_NUM_CH : default board clock, counter width, channel count
//   ch_w(n)    : width of a channel index able to also encode one out-of-range value
//   div_sat(x) : divisor saturation, 0 maps to 1
package tick_div_pkg;
    localparam int DEF_CLK_HZ = 12000000;
    localparam int DEF_CNT_W = 24;
    localparam int DEF_NUM_CH = 4;
    // One extra code point so an out-of-range channel request is representable
    // even when NUM_CH is a power of two.
    function automatic int ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction
    localparam int DEF_CH_W = ch_w(DEF_NUM_CH);
    function automatic logic [31:0] div_sat(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction
endpackage

// File: rtl/prog_tick_divider_if.sv
// prog_tick_divider_if: control and output bundle of the tick divider.
//   ch_en, sync_clr, load_valid, load_ch, load_div : controller -> divider
//   load_err, tick, sq                             : divider -> controller
interface prog_tick_divider_if import tick_div_pkg::*; #(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W = DEF_CNT_W
);
    localparam int CH_W = ch_w(NUM_CH);
    logic [NUM_CH-1:0] ch_en;
    logic sync_clr;
    logic load_valid;
    logic [CH_W-1:0] load_ch;
    logic [CNT_W-1:0] load_div;
    logic load_err;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    modport master (
        output ch_en, sync_clr, load_valid, load_ch, load_div,
        input load_err, tick, sq
    );
    modport slave (
        input ch_en, sync_clr, load_valid, load_ch, load_div,
        output load_err, tick, sq
    );
endinterface

// File: rtl/prog_tick_divider_ch.sv
// prog_tick_div_ch: one divider channel with shadowed divisor reload at wrap.
//   clk, rst : clock, async active-high reset
//   en       : run enable; clr : sync clear of counter/tick/sq
//   wr       : divisor write strobe; wr_div : new divisor (0 treated as 1)
//   tick     : one-cycle strobe per period; sq : toggles on every tick
module prog_tick_div_ch import tick_div_pkg::*; #(
    parameter int CNT_W = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEF_CLK_HZ / 2)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic tick,
    output logic sq
);
    logic [CNT_W-1:0] cnt, active_div, shadow_div, div_in;
    logic pending, wrap;
    assign div_in = CNT_W'(div_sat(32'(wr_div)));
    assign wrap = cnt == active_div - 1'b1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            active_div <= DEF_DIV;
            shadow_div <= DEF_DIV;
            pending <= 1'b0;
            tick <= 1'b0;
            sq <= 1'b0;
        end else begin
            if (wr) begin
                shadow_div <= div_in;
                pending <= 1'b1;
            end
            if (clr) begin
                cnt <= '0;
                tick <= 1'b0;
                sq <= 1'b0;
            end else if (!en) begin
                cnt <= '0;
                tick <= 1'b0;
                // a write on this edge lands in the shadow and is applied next edge
                if (pending && !wr) begin
                    active_div <= shadow_div;
                    pending <= 1'b0;
                end
            end else if (wrap) begin
                cnt <= '0;
                tick <= 1'b1;
                sq <= ~sq;
                // a write coinciding with the wrap bypasses the shadow
                if (wr || pending) begin
                    active_div <= wr ? div_in : shadow_div;
                    pending <= 1'b0;
                end
            end else begin
                cnt <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/prog_tick_divider.sv
// prog_tick_divider: multi-channel programmable clock-enable generator.
//   BOARD_CLK : system clock; BOARD_RST : async active-high reset
//   bus       : ch_en/sync_clr/load_* in, load_err/tick/sq out (slave modport)
module prog_tick_divider import tick_div_pkg::*; #(
    parameter int CLK_HZ = DEF_CLK_HZ,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int DEF_DIV = CLK_HZ / 2
) (
    input  logic BOARD_CLK,
    input  logic BOARD_RST,
    prog_tick_divider_if.slave bus
);
    localparam int CH_W = ch_w(NUM_CH);
    logic [NUM_CH-1:0] tick, sq;
    logic load_err;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        prog_tick_div_ch #(
            .CNT_W(CNT_W),
            .DEF_DIV(CNT_W'(DEF_DIV))
        ) u_ch (
            .clk(BOARD_CLK),
            .rst(BOARD_RST),
            .en(bus.ch_en[i]),
            .clr(bus.sync_clr),
            .wr(bus.load_valid && bus.load_ch == CH_W'(i)),
            .wr_div(bus.load_div),
            .tick(tick[i]),
            .sq(sq[i])
        );
    end
    always_ff @(posedge BOARD_CLK or posedge BOARD_RST) begin
        if (BOARD_RST) load_err <= 1'b0;
        else load_err <= bus.load_valid && bus.load_ch >= CH_W'(NUM_CH);
    end
    assign bus.tick = tick;
    assign bus.sq = sq;
    assign bus.load_err = load_err;
endmodule
